// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_multi
// Purpose  : Per-channel synchronise, glitch-filter and edge-detect with
//            one-cycle event strobes and sticky flags.
// Revision : 1.0
// ============================================================================
module edge_detect_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH-1:0]      a,
    input  logic [2*N_CH-1:0]    mode,
    input  logic [FILT_W-1:0]    filt_len,
    input  logic [N_CH-1:0]      clr,
    output logic [N_CH-1:0]      pulse,
    output logic [N_CH-1:0]      stat,
    output logic [N_CH-1:0]      lvl,
    output logic                 any_evt
);

    logic [N_CH-1:0] w_pulse;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [FILT_W-1:0]      r_cnt;
            logic                   r_lvl;
            logic                   r_pulse;
            logic                   r_stat;
            logic                   w_s;
            logic                   w_diff;
            logic                   w_accept;
            logic                   w_evt;

            assign w_s    = r_sync[SYNC_STAGES-1];
            assign w_diff = w_s ^ r_lvl;
            // ">=" rather than "==" so a shortened filter length mid-count
            // still commits on the next edge instead of wrapping the counter.
            assign w_accept = w_diff && (r_cnt >= filt_len);
            assign w_evt    = w_accept &&
                              ((w_s && mode[2*i]) || (!w_s && mode[2*i+1]));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync  <= '0;
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                    r_pulse <= 1'b0;
                    r_stat  <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], a[i]};
                    if (!w_diff || w_accept) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        r_lvl <= w_s;
                    end
                    r_pulse <= w_evt;
                    // A set in the same cycle as a clear wins.
                    r_stat  <= w_evt | (r_stat & ~clr[i]);
                end
            end

            assign w_pulse[i] = r_pulse;
            assign stat[i]    = r_stat;
            assign lvl[i]     = r_lvl;
        end
    endgenerate

    assign pulse   = w_pulse;
    assign any_evt = |w_pulse;

endmodule
`default_nettype wire

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of independent channels (legal 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving synchroniser depth per channel (legal 2..4).
REQ-003 The block SHALL have parameter FILT_W, default 4, giving the glitch-filter counter width (legal 1..8).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 a  input  N_CH  asynchronous channel inputs.
REQ-007 mode  input  2*N_CH  per-channel mode; bits [2i+1:2i] are for channel i: 00 off, 01 rising, 10 falling, 11 both.
REQ-008 filt_len  input  FILT_W  filter length L, shared by all channels; synchronous, may change at any time.
REQ-009 clr  input  N_CH  per-channel sticky-flag clear, level-sensitive.
REQ-010 pulse  output  N_CH  registered one-cycle event strobe per channel.
REQ-011 stat  output  N_CH  registered sticky event flag per channel.
REQ-012 lvl  output  N_CH  registered filtered level per channel.
REQ-013 any_evt  output  1  OR of all pulse bits.

Function
REQ-014 Each channel SHALL pass a[i] through a SYNC_STAGES-deep flip-flop chain; the last stage is s[i].
REQ-015 Each channel SHALL hold a counter cnt[i] of FILT_W bits and a filtered level lvl[i].
REQ-016 Each edge, when s[i] == lvl[i], cnt[i] SHALL load 0.
REQ-017 Each edge, when s[i] != lvl[i] and cnt[i] < L, cnt[i] SHALL increment by 1.
REQ-018 Each edge, when s[i] != lvl[i] and cnt[i] >= L, lvl[i] SHALL load s[i] and cnt[i] SHALL load 0. The >= comparison covers L being reduced mid-count.
REQ-019 A change on s[i] SHALL be accepted only if it holds for L+1 consecutive cycles; shorter excursions SHALL leave lvl[i] unchanged and produce no pulse.
REQ-020 pulse[i] SHALL be set on the same edge that lvl[i] changes 0->1 when the mode is 01 or 11.
REQ-021 pulse[i] SHALL be set on the same edge that lvl[i] changes 1->0 when the mode is 10 or 11.
REQ-022 pulse[i] SHALL be 0 on every other edge, so it is exactly one cycle wide.
REQ-023 Latency from a[i] change (sampled at edge 0) to pulse[i]/lvl[i] update SHALL be SYNC_STAGES+1+L edges.
REQ-024 Mode 00 SHALL suppress pulse[i] and stat[i] setting, while lvl[i] continues to track.
REQ-025 A mode change SHALL take effect on the next edge and SHALL NOT produce a retroactive pulse for an earlier lvl change.
REQ-026 stat[i] SHALL be set when pulse[i] is set.
REQ-027 stat[i] SHALL be cleared on an edge with clr[i]=1 and no simultaneous set.
REQ-028 A simultaneous set and clear of stat[i] SHALL leave stat[i]=1 (set wins).
REQ-029 any_evt SHALL be the combinational OR of the pulse register bits; no other output has a combinational path from any input.
REQ-030 Channels SHALL be fully independent, and simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-031 While rst_n=0, all synchroniser stages, cnt, lvl, pulse and stat SHALL be 0, and any_evt SHALL be 0.
REQ-032 Reset assertion mid-count SHALL discard the pending filter count; no pulse SHALL follow reset assertion.
REQ-033 An input that is high at reset release SHALL be reported as a rising edge after SYNC_STAGES+1+L edges, if the mode allows it.

Verification
REQ-034 Basic rising and falling edges (default parameters, L=0, mode=11 on ch0, a[0] 0->1 then 1->0 after 10 cycles) -> pulse[0] high exactly one cycle, 3 edges after each change; lvl[0] follows; stat[0]=1.
REQ-035 Glitch filter (L=3, mode=01; 3-cycle high glitch, then 4-cycle high) -> no pulse for the glitch; one pulse 6 edges after the start of the 4-cycle high.
REQ-036 Per-channel mode selection (channels 0..3 at 00/01/10/11; all a toggle together 0->1->0) -> ch0 no pulses; ch1 one pulse on rise; ch2 one pulse on fall; ch3 two pulses; any_evt mirrors these.
REQ-037 Sticky flag set/clear collision (clr[1] held high in the cycle pulse[1] asserts) -> stat[1]=1; clr[1] on a later edge with no pulse -> stat[1]=0.
REQ-038 Reset and filter-length corner cases: rst_n pulsed low during a pending L=5 count -> all outputs 0, no pulse afterwards. Separately, L reduced from 7 to 1 while cnt=4 -> lvl updates on the next edge.
